radio_timing_engine_mc: RTL and testbench

//  Multi-channel successor of the two-stage radio timing engine. Per channel:
//  - synchronises the async enable/RX requests and PLL-settled flag;
//  - waits for PLL lock, then a programmable tArstFs settle delay;
//  - drives registered radioEnable/radioRxEn to the RF front-end.

---
 rtl/radio_timing_engine_mc.sv | 136 +++++++++++++
 tb/tb_radio_timing_engine_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radio_timing_engine_mc.sv
// radio_timing_engine_mc: per-channel radio enable sequencer with PLL-lock wait and settle delay
//
// Ports:
//   clk                 in   single clock for all logic
//   rst                 in   asynchronous active-high reset
//   radioEnableUnsynced in   [NUM_CH]       async enable request per channel
//   radioRxEnUnsynced   in   [NUM_CH]       async mode request, 1=RX 0=TX
//   pllSettled          in   [NUM_CH]       async PLL-lock flag per channel
//   tArstFs             in   [NUM_CH*CNT_W] settle delay, channel i at [i*CNT_W +: CNT_W]
//   radioEnable         out  [NUM_CH]       registered radio enable
//   radioRxEn           out  [NUM_CH]       registered RX select, 0 while disabled
//   enabledPulse        out  [NUM_CH]       one-cycle pulse with the first enabled cycle
//   pllTimeout          out  [NUM_CH]       sticky PLL watchdog error
//   busy                out                 any channel outside IDLE
//
// Build option: define TE_PLL_TIMEOUT_EN to add the WAIT_PLL watchdog and ERROR
// state; otherwise WAIT_PLL waits forever and pllTimeout is tied low.
module radio_timing_engine_mc #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PLL_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       radioEnableUnsynced,
    input  logic [NUM_CH-1:0]       radioRxEnUnsynced,
    input  logic [NUM_CH-1:0]       pllSettled,
    input  logic [NUM_CH*CNT_W-1:0] tArstFs,
    output logic [NUM_CH-1:0]       radioEnable,
    output logic [NUM_CH-1:0]       radioRxEn,
    output logic [NUM_CH-1:0]       enabledPulse,
    output logic [NUM_CH-1:0]       pllTimeout,
    output logic                    busy
);
    typedef enum logic [2:0] {IDLE, WAIT_PLL, COUNT, ACTIVE, ERROR} state_t;

    logic [NUM_CH-1:0] live;

    assign busy = |live;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (PLL_TIMEOUT < 1) begin : g_bad_timeout
        $error("PLL_TIMEOUT must be at least 1");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] req_p, rx_p, pll_p;
        logic                   req_s, rx_s, pll_s;
        logic                   rx_mode, en_d, en_q, rxen_q, pulse_q, timed_out;
        logic [CNT_W-1:0]       cnt, dly;
        state_t                 state, next;

        assign req_s   = req_p[SYNC_STAGES-1];
        assign rx_s    = rx_p[SYNC_STAGES-1];
        assign pll_s   = pll_p[SYNC_STAGES-1];
        assign dly     = tArstFs[c*CNT_W +: CNT_W];
        assign live[c] = state != IDLE;

        // A zero delay enters ACTIVE straight from WAIT_PLL; holding the enable
        // back on that edge keeps the rise at one cycle, same as a delay of one.
        assign en_d = next == ACTIVE && state != WAIT_PLL;

        assign radioEnable[c]  = en_q;
        assign radioRxEn[c]    = rxen_q;
        assign enabledPulse[c] = pulse_q;

        always_comb begin
            next = state;
            case (state)
                IDLE:     next = req_s ? WAIT_PLL : IDLE;
                WAIT_PLL: next = !req_s ? IDLE : pll_s ? (dly == '0 ? ACTIVE : COUNT) : timed_out ? ERROR : WAIT_PLL;
                COUNT:    next = (!req_s || !pll_s) ? IDLE : cnt == CNT_W'(1) ? ACTIVE : COUNT;
                ACTIVE:   next = !req_s ? IDLE : (!pll_s || rx_s != rx_mode) ? WAIT_PLL : ACTIVE;
                ERROR:    next = req_s ? ERROR : IDLE;
                default:  next = IDLE;
            endcase
        end

        // Delay and mode reload every WAIT_PLL cycle; the copy taken on the exit
        // edge is the one that governs COUNT/ACTIVE.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                req_p   <= '0;
                rx_p    <= '0;
                pll_p   <= '0;
                state   <= IDLE;
                cnt     <= '0;
                rx_mode <= 1'b0;
                en_q    <= 1'b0;
                rxen_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                req_p   <= {req_p[SYNC_STAGES-2:0], radioEnableUnsynced[c]};
                rx_p    <= {rx_p[SYNC_STAGES-2:0], radioRxEnUnsynced[c]};
                pll_p   <= {pll_p[SYNC_STAGES-2:0], pllSettled[c]};
                state   <= next;
                if (state == WAIT_PLL) begin
                    cnt     <= dly;
                    rx_mode <= rx_s;
                end else if (state == COUNT) begin
                    cnt <= cnt - 1'b1;
                end
                en_q    <= en_d;
                rxen_q  <= en_d & rx_mode;
                pulse_q <= en_d & ~en_q;
            end
        end

`ifdef TE_PLL_TIMEOUT_EN
        localparam int WD_W = $clog2(PLL_TIMEOUT + 1);
        logic [WD_W-1:0] wd;
        logic            to_q;

        // wd holds the number of completed WAIT_PLL cycles; it is zero on any
        // cycle outside WAIT_PLL so every entry starts a fresh count.
        assign timed_out     = wd == WD_W'(PLL_TIMEOUT - 1);
        assign pllTimeout[c] = to_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wd   <= '0;
                to_q <= 1'b0;
            end else begin
                wd   <= (state == WAIT_PLL) ? wd + 1'b1 : '0;
                to_q <= next == ERROR;
            end
        end
`else
        assign timed_out     = 1'b0;
        assign pllTimeout[c] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_radio_timing_engine_mc.sv
// tb_radio_timing_engine_mc: directed and random checks of radio_timing_engine_mc against a timestamp model
module tb_radio_timing_engine_mc;
    localparam int NC = 2;
    localparam int CW = 8;
    localparam int SS = 2;
    localparam int PT = 20;
`ifdef TE_PLL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_WAIT = 1, M_SETTLE = 2, M_ON = 3, M_ERR = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   req_in, rx_in, pll_in;
    logic [NC*CW-1:0] tfs;
    logic [NC-1:0]   en, rxen, pulse, pto;
    logic            busy;

    always #5 clk = ~clk;

    radio_timing_engine_mc #(
        .NUM_CH(NC), .CNT_W(CW), .SYNC_STAGES(SS), .PLL_TIMEOUT(PT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .radioEnableUnsynced(req_in),
        .radioRxEnUnsynced(rx_in),
        .pllSettled(pll_in),
        .tArstFs(tfs),
        .radioEnable(en),
        .radioRxEn(rxen),
        .enabledPulse(pulse),
        .pllTimeout(pto),
        .busy(busy)
    );

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int n;
    int m_st[NC], m_at[NC], m_wst[NC];
    bit m_rx[NC], e_en[NC], e_rx[NC], e_pl[NC], e_to[NC];
    bit q_req[NC][SS], q_rx[NC][SS], q_pll[NC][SS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_st[c] = M_IDLE;
            m_rx[c] = 1'b0;
            e_en[c] = 1'b0;
            e_rx[c] = 1'b0;
            e_pl[c] = 1'b0;
            e_to[c] = 1'b0;
            for (int k = 0; k < SS; k++) begin
                q_req[c][k] = 1'b0;
                q_rx[c][k]  = 1'b0;
                q_pll[c][k] = 1'b0;
            end
        end
    endtask

    // Each channel is described by its phase plus absolute cycle stamps: when the
    // enable is due and when the current PLL wait began.
    task automatic model_step();
        cyc++;
        for (int c = 0; c < NC; c++) begin
            bit rs, xs, ps, was;
            int t;
            rs  = q_req[c][SS-1];
            xs  = q_rx[c][SS-1];
            ps  = q_pll[c][SS-1];
            t   = int'(tfs[c*CW +: CW]);
            was = e_en[c];
            case (m_st[c])
                M_IDLE: if (rs) begin m_st[c] = M_WAIT; m_wst[c] = cyc; end
                M_WAIT: begin
                    if (!rs) m_st[c] = M_IDLE;
                    else if (ps) begin
                        m_rx[c] = xs;
                        m_st[c] = (t == 0) ? M_ON : M_SETTLE;
                        m_at[c] = cyc + ((t == 0) ? 1 : t);
                    end else if (TO_EN && cyc - m_wst[c] == PT) m_st[c] = M_ERR;
                end
                M_SETTLE: begin
                    if (!rs || !ps) m_st[c] = M_IDLE;
                    else if (cyc == m_at[c]) m_st[c] = M_ON;
                end
                M_ON: begin
                    if (!rs) m_st[c] = M_IDLE;
                    else if (!ps || xs != m_rx[c]) begin m_st[c] = M_WAIT; m_wst[c] = cyc; end
                end
                default: if (!rs) m_st[c] = M_IDLE;
            endcase
            e_en[c] = m_st[c] == M_ON && cyc >= m_at[c];
            e_pl[c] = e_en[c] && !was;
            e_rx[c] = e_en[c] && m_rx[c];
            e_to[c] = m_st[c] == M_ERR;
            for (int k = SS - 1; k > 0; k--) begin
                q_req[c][k] = q_req[c][k-1];
                q_rx[c][k]  = q_rx[c][k-1];
                q_pll[c][k] = q_pll[c][k-1];
            end
            q_req[c][0] = req_in[c];
            q_rx[c][0]  = rx_in[c];
            q_pll[c][0] = pll_in[c];
        end
    endtask

    task automatic check_all();
        bit b;
        b = 1'b0;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("en%0d@%0d", c, cyc), en[c], e_en[c]);
            chk($sformatf("rxen%0d@%0d", c, cyc), rxen[c], e_rx[c]);
            chk($sformatf("pulse%0d@%0d", c, cyc), pulse[c], e_pl[c]);
            chk($sformatf("pto%0d@%0d", c, cyc), pto[c], e_to[c]);
            if (m_st[c] != M_IDLE) b = 1'b1;
        end
        chk($sformatf("busy@%0d", cyc), busy, b);
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    // kind 0: enable rises, 1: enable falls, 2: timeout flag rises; n=-1 if bound expires
    task automatic wait_for(input int c, input int kind, input int bound, output int cnt);
        cnt = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if ((kind == 0 && en[c] === 1'b1) || (kind == 1 && en[c] === 1'b0) ||
                (kind == 2 && pto[c] === 1'b1)) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic set_ch(input int c, input bit r, input bit x, input bit p, input int t);
        req_in[c] = r;
        rx_in[c]  = x;
        pll_in[c] = p;
        tfs[c*CW +: CW] = CW'(t);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rxen", rxen, 0);
        model_reset();
        req_in = '0;
        rx_in  = '0;
        pll_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req_in = '0;
        rx_in  = '0;
        pll_in = '0;
        tfs    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_en", en, 0);
        chk("init_busy", busy, 0);
        chk("init_pto", pto, 0);
        rst = 1'b0;
        tick(2);

        // ch0, delay 5, RX mode
        set_ch(0, 1, 1, 1, 5);
        wait_for(0, 0, 40, n);
        chk("rise_t5", n, 9);
        chk("rxen0_on", rxen[0], 1);
        chk("pulse0_on", pulse[0], 1);
        tick(1);
        chk("pulse0_once", pulse[0], 0);
        chk("ch1_quiet", {en[1], rxen[1], pulse[1]}, 0);
        tick(3);
        chk("pre_rst_en", en[0], 1);
        do_reset();

        // zero delay, then a delay changed mid-count
        set_ch(0, 1, 0, 1, 0);
        wait_for(0, 0, 40, n);
        chk("rise_t0", n, 5);
        chk("rxen0_tx", rxen[0], 0);
        set_ch(0, 0, 0, 1, 0);
        wait_for(0, 1, 40, n);
        chk("fall_req", n, 3);
        tick(4);
        set_ch(0, 1, 1, 1, 10);
        tick(6);
        tfs[0 +: CW] = CW'(3);
        wait_for(0, 0, 40, n);
        chk("rise_t10_kept", n, 8);
        set_ch(0, 0, 0, 0, 0);
        tick(5);

        // ch1 mode change re-settles
        set_ch(1, 1, 1, 1, 4);
        wait_for(1, 0, 40, n);
        chk("rise1_t4", n, 8);
        rx_in[1] = 1'b0;
        wait_for(1, 1, 40, n);
        chk("fall1_mode", n, 3);
        wait_for(1, 0, 40, n);
        chk("rerise1", n, 5);
        chk("rxen1_tx", rxen[1], 0);

        // lock loss during COUNT restarts the wait
        set_ch(0, 1, 0, 1, 8);
        tick(6);
        pll_in[0] = 1'b0;
        tick(4);
        chk("lockloss_off", en[0], 0);
        pll_in[0] = 1'b1;
        wait_for(0, 0, 40, n);
        chk("lockloss_rerise", n, 11);
        set_ch(0, 0, 0, 0, 0);
        tick(4);

        // request drop together with mode change goes idle, not back to wait
        req_in[1] = 1'b0;
        rx_in[1]  = 1'b1;
        wait_for(1, 1, 40, n);
        chk("fall1_req_mode", n, 3);
        chk("busy_idle", busy, 0);
        tick(3);

        // concurrent channels
        set_ch(0, 1, 1, 1, 3);
        set_ch(1, 1, 0, 1, 7);
        wait_for(0, 0, 40, n);
        chk("conc_rise0", n, 7);
        wait_for(1, 0, 40, n);
        chk("conc_rise1", n, 4);
        chk("conc_en0", en[0], 1);
        set_ch(0, 0, 0, 0, 0);
        set_ch(1, 0, 0, 0, 0);
        tick(4);

        // PLL never locks
        set_ch(0, 1, 0, 0, 2);
        wait_for(0, 2, 40, n);
        chk("pll_timeout", n, TO_EN ? 23 : -1);
        set_ch(0, 0, 0, 0, 0);
        tick(4);
        chk("timeout_clear", pto[0], 0);
        chk("timeout_busy", busy, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 11) == 0) begin
                    req_in[c] = ~req_in[c];
                    tfs[c*CW +: CW] = CW'($urandom_range(0, 6));
                end
                if ($urandom_range(0, 13) == 0) pll_in[c] = ~pll_in[c];
                if ($urandom_range(0, 17) == 0) rx_in[c] = ~rx_in[c];
            end
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
